fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch initiator for the port-1 (instruction) side of the dual-port block memory.
//   Owns the fetch PC and drives the memory address. Captures the returned word, which arrives a fixed
//   one cycle later. Buffers up to two fetched words and presents them to decode with a valid/ready
//   handshake. Supports control-flow redirects that kill any in-flight and buffered fetches.
// PARAMETERS
//   ADDR_W    16      word-address width (memory is word-addressed)
//   DATA_W    16      instruction word width
//   RESET_PC  16'h0   first fetch address after reset
// PORTS
//   clk          in   1       system clock, all logic on posedge
//   reset        in   1       synchronous, active-high reset
//   mem_addr     out  ADDR_W  fetch address to memory port 1; equals fetch_pc register
//   mem_word     in   DATA_W  memory read data; valid the cycle after its address is presented
//   redirect     in   1       1-cycle pulse: discard pending fetches, restart at redirect_pc
//   redirect_pc  in   ADDR_W  new fetch address, sampled when redirect=1
//   instr_valid  out  1       buffer head holds a valid instruction
//   instr        out  DATA_W  instruction at buffer head
//   instr_pc     out  ADDR_W  address of instr
//   instr_ready  in   1       decode accepts head; pop = instr_valid & instr_ready
// BEHAVIOUR
//   State: fetch_pc; inflight flag + inflight_pc (one outstanding read); 2-entry FIFO (count 0..2).
//   Outputs are registered or come straight from registers. There is no combinational path from
//     any input to any output.
//   Reset (takes priority over everything): fetch_pc=RESET_PC, inflight=0, count=0,
//     instr_valid=0, instr=0, instr_pc=0.
//   Issue rule (non-reset, non-redirect cycle):
//     issue = (count + inflight - pop) < 2.
//     On issue, inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (mod 2^ADDR_W, FFFF->0000).
//     Otherwise inflight<=0 and fetch_pc holds.
//   Return: if inflight=1, mem_word in this cycle belongs to inflight_pc.
//     It is written to the FIFO tail at the end of the cycle.
//     The issue rule guarantees a free slot (after any same-cycle pop).
//   Pop and push in the same cycle are legal and leave count unchanged. Order is strictly FIFO.
//   Latency: address issued in cycle k -> word in FIFO at end of k+1 -> instr_valid in k+2 if FIFO was empty.
//   Steady state with instr_ready=1: one instruction per cycle after the initial 2-cycle fill.
//   Stall: instr_ready=0 holds instr/instr_pc stable. Fetching stops once count+inflight reaches 2.
//     No word is lost or duplicated.
//   Redirect (cycle r):
//     count<=0 and inflight<=0; any mem_word returning in r is discarded; fetch_pc<=redirect_pc.
//     No issue in r.
//     A same-cycle pop of the old head is still accepted by decode. The old entry is flushed anyway.
//     redirect_pc is issued in r+1; instr_valid=1 with instr_pc=redirect_pc in r+3.
//   Back-to-back redirects: the last one wins. Each resets the r+3 latency.
//   Reset mid-operation: all state is discarded exactly as at power-up. The first issue of RESET_PC
//     is in the first cycle with reset=0.
//   mem_addr is always driven from fetch_pc. A read the unit does not track is harmless and ignored.
// TESTING
//   1. Reset, memory preloaded mem[0..3]=A0,A1,A2,A3, instr_ready=1 -> instr_valid rises 2 cycles after
//      reset release; instr/instr_pc = A0/0, A1/1, A2/2, A3/3 on consecutive cycles.
//   2. instr_ready=0 for 5 cycles mid-stream -> instr frozen, count saturates at 2, mem_addr stops
//      advancing; on release, sequence continues with no gap in PC and no duplicates.
//   3. Redirect to 16'h0040 while FIFO full and a read in flight -> old words never appear;
//      3 cycles later instr_pc=0x0040, then 0x0041...
//   4. Redirect in the same cycle as a pop, and two redirects on consecutive cycles (0x10 then 0x20)
//      -> only 0x20 stream is delivered.
//   5. RESET_PC=16'hFFFE -> instr_pc sequence FFFE, FFFF, 0000, 0001 (address wrap).
//   6. Assert reset for 1 cycle mid-stream with FIFO full -> instr_valid=0 next cycle; restart
//      from RESET_PC with the step-1 timing.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator for the instruction port of the block memory: owns the fetch PC,
// tracks one outstanding read and buffers up to two returned words for decode.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_word,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic [1:0]        r_count;
    logic              r_valid;
    logic [DATA_W-1:0] r_word0, r_word1;
    logic [ADDR_W-1:0] r_pc0, r_pc1;

    logic              w_pop;
    logic              w_issue;
    logic [2:0]        w_occ;
    logic [1:0]        w_cnt_pop;
    logic [1:0]        w_count_n;
    logic [DATA_W-1:0] w_word0_n, w_word1_n;
    logic [ADDR_W-1:0] w_pc0_n, w_pc1_n;

    assign mem_addr    = r_fetch_pc;
    assign instr_valid = r_valid;
    assign instr       = r_word0;
    assign instr_pc    = r_pc0;

    // Slot 0 is the head; a pop shifts slot 1 down before the returning word lands in the first free slot.
    always_comb begin
        w_pop     = r_valid & instr_ready;
        w_occ     = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_issue   = (w_occ < 3'd2);
        w_cnt_pop = r_count - {1'b0, w_pop};
        w_count_n = w_cnt_pop + {1'b0, r_inflight};
        w_word0_n = r_word0;
        w_pc0_n   = r_pc0;
        w_word1_n = r_word1;
        w_pc1_n   = r_pc1;
        if (w_pop) begin
            w_word0_n = r_word1;
            w_pc0_n   = r_pc1;
        end
        if (r_inflight) begin
            if (w_cnt_pop == 2'd0) begin
                w_word0_n = mem_word;
                w_pc0_n   = r_inflight_pc;
            end else begin
                w_word1_n = mem_word;
                w_pc1_n   = r_inflight_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_count       <= '0;
            r_valid       <= 1'b0;
            r_word0       <= '0;
            r_pc0         <= '0;
            r_word1       <= '0;
            r_pc1         <= '0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + ADDR_W'(1);
            end
            r_count <= w_count_n;
            r_valid <= (w_count_n != 2'd0);
            r_word0 <= w_word0_n;
            r_pc0   <= w_pc0_n;
            r_word1 <= w_word1_n;
            r_pc1   <= w_pc1_n;
        end
    end

endmodule
